// File: rtl/conv3x3_win_ctrl.sv
// -----------------------------------------------------------------------------
// conv3x3_win_ctrl
// Sequencing controller for a 3x3 RGB window generator. Accepts one frame as a
// valid/ready pixel stream and drives the generator's shift/line-buffer write
// enable. It inserts a zero pad column after every line and a zero pad row
// after the last line, so every pixel (including the bottom/right edges) gets
// a centred window.
//
// Scan grid is (IMG_H+1) x (IMG_W+1). A shift at grid position (sr,sc) with
// sr>=1 and sc>=1 completes the window centred at (sr-1, sc-1).
//
// Ports:
//   clk          system clock (rising edge)
//   rst          asynchronous active-high reset
//   frame_start  single-cycle frame request, honoured only in IDLE
//   in_valid     upstream pixel present
//   in_ready     pixel accepted this cycle (RUN state)
//   shift_en     advance window registers / write line buffers
//   pad_zero     generator shifts zero instead of the input pixel
//   win_valid    window outputs hold a complete window (registered)
//   win_row/col  centre coordinates of the current window (registered)
//   brd_top/bot/lft/rgt  centre lies on first/last row, first/last column
//   busy         frame in progress
//   frame_done   one-cycle pulse in the cycle after the last window
//   err_ovr      sticky protocol error
//
// Optional feature macro: CONV3X3_CTRL_ERR_EN
//   defined   -> err_ovr flags frame_start while busy, or in_valid during a
//                pad slot (PAD/FLUSH); sticky until rst
//   undefined -> err_ovr tied to 0
// -----------------------------------------------------------------------------
module conv3x3_win_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_en,
  output logic             pad_zero,
  output logic             win_valid,
  output logic [CNT_W-1:0] win_row,
  output logic [CNT_W-1:0] win_col,
  output logic             brd_top,
  output logic             brd_bot,
  output logic             brd_lft,
  output logic             brd_rgt,
  output logic             busy,
  output logic             frame_done,
  output logic             err_ovr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAD,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_W      = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] C_W_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] C_H      = CNT_W'(IMG_H);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_sr, r_sc, w_sr_next, w_sc_next;
  logic             w_win_fire;

  logic             r_win_valid, r_frame_done;
  logic [CNT_W-1:0] r_win_row, r_win_col;
  logic             r_brd_top, r_brd_bot, r_brd_lft, r_brd_rgt;

  // State and scan-position registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_sc    <= '0;
    end else begin
      r_state <= w_state_next;
      r_sr    <= w_sr_next;
      r_sc    <= w_sc_next;
    end
  end

  // Next-state, counter update and combinational handshake decode
  always_comb begin
    w_state_next = r_state;
    w_sr_next    = r_sr;
    w_sc_next    = r_sc;
    in_ready     = 1'b0;
    shift_en     = 1'b0;
    pad_zero     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_state_next = S_RUN;
          w_sr_next    = '0;
          w_sc_next    = '0;
        end
      end
      S_RUN: begin
        in_ready = 1'b1;
        shift_en = in_valid;
        if (in_valid) begin
          w_sc_next = r_sc + C_ONE;
          // Last active pixel of the line: next slot is the right pad column
          if (r_sc == C_W_LAST) w_state_next = S_PAD;
        end
      end
      S_PAD: begin
        shift_en  = 1'b1;
        pad_zero  = 1'b1;
        w_sc_next = '0;
        w_sr_next = r_sr + C_ONE;
        w_state_next = ((r_sr + C_ONE) == C_H) ? S_FLUSH : S_RUN;
      end
      S_FLUSH: begin
        shift_en = 1'b1;
        pad_zero = 1'b1;
        if (r_sc == C_W) begin
          w_sc_next    = '0;
          w_state_next = S_DONE;
        end else begin
          w_sc_next = r_sc + C_ONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign busy = (r_state != S_IDLE);

  // Row 0 and column 0 of the scan grid only prime the window; no centre yet
  assign w_win_fire = shift_en && (r_sr != '0) && (r_sc != '0);

  // Window descriptor registers; coordinates and flags hold between windows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_valid  <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
      r_brd_top    <= 1'b0;
      r_brd_bot    <= 1'b0;
      r_brd_lft    <= 1'b0;
      r_brd_rgt    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_win_valid  <= w_win_fire;
      r_frame_done <= (r_state == S_DONE);
      if (w_win_fire) begin
        r_win_row <= r_sr - C_ONE;
        r_win_col <= r_sc - C_ONE;
        // Flags decoded from the shift position, which is centre + 1
        r_brd_top <= (r_sr == C_ONE);
        r_brd_bot <= (r_sr == C_H);
        r_brd_lft <= (r_sc == C_ONE);
        r_brd_rgt <= (r_sc == C_W);
      end
    end
  end

  assign win_valid  = r_win_valid;
  assign win_row    = r_win_row;
  assign win_col    = r_win_col;
  assign brd_top    = r_brd_top;
  assign brd_bot    = r_brd_bot;
  assign brd_lft    = r_brd_lft;
  assign brd_rgt    = r_brd_rgt;
  assign frame_done = r_frame_done;

`ifdef CONV3X3_CTRL_ERR_EN
  logic r_err_ovr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_ovr <= 1'b0;
    end else if ((frame_start && busy) ||
                 (in_valid && ((r_state == S_PAD) || (r_state == S_FLUSH)))) begin
      r_err_ovr <= 1'b1;
    end
  end
  assign err_ovr = r_err_ovr;
`else
  assign err_ovr = 1'b0;
`endif

endmodule

// File: tb/tb_conv3x3_win_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for conv3x3_win_ctrl with IMG_W=4, IMG_H=3.
// The driver pushes the expected window sequence of each frame into a
// scoreboard queue when it issues frame_start; a separate monitor pops and
// compares on every win_valid and checks pad placement and frame_done timing.
// -----------------------------------------------------------------------------
module tb_conv3x3_win_ctrl;

  localparam int W      = 4;
  localparam int H      = 3;
  localparam int CW     = 12;
  localparam int NWIN   = W * H;
  localparam int NSHIFT = (W + 1) * (H + 1);
`ifdef CONV3X3_CTRL_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk, rst, frame_start, in_valid;
  logic          in_ready, shift_en, pad_zero, win_valid;
  logic [CW-1:0] win_row, win_col;
  logic          brd_top, brd_bot, brd_lft, brd_rgt;
  logic          busy, frame_done, err_ovr;

  conv3x3_win_ctrl #(.IMG_W(W), .IMG_H(H), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
    .in_ready(in_ready), .shift_en(shift_en), .pad_zero(pad_zero),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
    .brd_top(brd_top), .brd_bot(brd_bot), .brd_lft(brd_lft), .brd_rgt(brd_rgt),
    .busy(busy), .frame_done(frame_done), .err_ovr(err_ovr)
  );

  typedef struct packed {
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          top;
    logic          bot;
    logic          lft;
    logic          rgt;
  } win_t;

  win_t sb[$];
  int   total = 0, bad = 0;
  int   cyc = 0;
  int   fs_edge = 0, exp_delta = 0;
  int   shift_cnt = 0, win_cnt = 0, last_win_cyc = 0, done_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (shift_en) begin
        shift_cnt++;
        // Right pad column every (W+1)th shift, then a full pad row at the end
        check("pad_zero", 64'(pad_zero),
              64'((shift_cnt % (W + 1) == 0) || (shift_cnt > H * (W + 1))));
      end
      if (win_valid) begin
        win_cnt++;
        last_win_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_window", 64'(1), 64'(0));
        end else begin
          win_t exp_w, act_w;
          exp_w = sb.pop_front();
          act_w.row = win_row; act_w.col = win_col;
          act_w.top = brd_top; act_w.bot = brd_bot;
          act_w.lft = brd_lft; act_w.rgt = brd_rgt;
          check("window", 64'(act_w), 64'(exp_w));
          $display("window row=%0d col=%0d tblr=%b%b%b%b", win_row, win_col,
                   brd_top, brd_bot, brd_lft, brd_rgt);
        end
      end
      if (frame_done) begin
        check("done_latency", 64'(cyc - fs_edge), 64'(exp_delta));
        check("done_after_last_win", 64'(cyc - last_win_cyc), 64'(1));
        check("shift_count", 64'(shift_cnt), 64'(NSHIFT));
        check("win_count", 64'(win_cnt), 64'(NWIN));
        $display("frame done at cycle %0d shifts=%0d windows=%0d", cyc, shift_cnt, win_cnt);
        shift_cnt = 0;
        win_cnt   = 0;
        done_seen++;
      end
    end
  end

  function automatic logic [34:0] all_outs();
    return {in_ready, shift_en, pad_zero, busy, win_valid, frame_done, err_ovr,
            brd_top, brd_bot, brd_lft, brd_rgt, win_row, win_col};
  endfunction

  task automatic push_frame();
    win_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        e.row = CW'(r); e.col = CW'(c);
        e.top = (r == 0); e.bot = (r == H - 1);
        e.lft = (c == 0); e.rgt = (c == W - 1);
        sb.push_back(e);
      end
    end
  endtask

  // Pulse frame_start; returns just after the sampling edge
  task automatic start_frame(input int delta);
    @(posedge clk); #1;
    push_frame();
    shift_cnt = 0;
    win_cnt   = 0;
    exp_delta = delta;
    fs_edge   = cyc + 1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done();
    int target, n;
    target = done_seen + 1;
    n = 0;
    while (done_seen < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("frame_done_seen", 64'(done_seen >= target), 64'(1));
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1; frame_start = 1'b0; in_valid = 1'b1;

    // Reset / idle: in_valid high but no frame_start
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_outputs", 64'(all_outs()), 64'(0));
    end

    // Frame A: uninterrupted
    start_frame(21);
    wait_done();
    check("err_after_frame_a", 64'(err_ovr), 64'(EXP_ERR));

    // Frame B: 3-cycle stall right after pixel (1,2) is accepted
    start_frame(24);
    repeat (8) @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_no_shift", 64'(shift_en), 64'(0));
      if (i >= 1) check("stall_no_window", 64'(win_valid), 64'(0));
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    wait_done();

    // Frame C: reset asserted during the bottom pad row
    start_frame(21);
    n = 0;
    while (shift_cnt < 17 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("reached_flush", 64'(shift_cnt >= 17), 64'(1));
    #3 rst = 1'b1;
    #1;
    check("async_reset_outputs", 64'(all_outs()), 64'(0));
    sb.delete();
    shift_cnt = 0;
    win_cnt   = 0;
    @(posedge clk); #1;
    check("reset_held_outputs", 64'(all_outs()), 64'(0));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("idle_after_reset", 64'(busy), 64'(0));

    // Frame D: full frame after reset, with a stray frame_start during RUN
    start_frame(21);
    repeat (3) @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    wait_done();
    check("err_after_frame_d", 64'(err_ovr), 64'(EXP_ERR));
    repeat (3) @(posedge clk);
    #1 check("idle_at_end", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
